frame_capture_sched: RTL and testbench

//  Sequences camera-frame capture into SDRAM for the OV5640 -> SDRAM -> LCD edge-detect path.

---
 rtl/frame_capture_sched.sv | 216 +++++++++++++++++++++
 tb/tb_frame_capture_sched.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/frame_capture_sched.sv
// Camera-to-SDRAM capture sequencer: warm-up skip, per-frame write gating, geometry check,
// triple-buffered bank rotation and frame-aligned threshold updates. Define FRAME_STATS_EN for counters.
module frame_capture_sched #(
    parameter int SKIP_FRAMES = 10,
    parameter int H_ACTIVE    = 480,
    parameter int V_ACTIVE    = 272,
    parameter int TH_W        = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cap_en,
    input  logic            i_vs,
    input  logic            i_de,
    input  logic [23:0]     i_data,
    input  logic [TH_W-1:0] cfg_th,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic            rd_sof,
    output logic            o_wr_en,
    output logic [23:0]     o_wr_data,
    output logic [1:0]      o_wr_bank,
    output logic [1:0]      o_rd_bank,
    output logic [TH_W-1:0] o_th,
    output logic            o_frame_err,
    output logic [15:0]     o_frame_cnt,
    output logic [7:0]      o_err_cnt
);
    localparam int PIX_W  = $clog2(H_ACTIVE + 2);
    localparam int LINE_W = $clog2(V_ACTIVE + 2);
    localparam int SKIP_W = $clog2(SKIP_FRAMES + 2);
    localparam logic [PIX_W-1:0]  PIX_MAX   = PIX_W'(H_ACTIVE + 1);
    localparam logic [LINE_W-1:0] LINE_MAX  = LINE_W'(V_ACTIVE + 1);
    localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'((SKIP_FRAMES > 0) ? SKIP_FRAMES - 1 : 0);

    typedef enum logic [2:0] {IDLE, SKIP, WAIT_SOF, CAPTURE, COMMIT} state_t;

    state_t             state_q, state_d;
    logic [SKIP_W-1:0]  skip_cnt_q, skip_cnt_d;
    logic               vs_d_q, de_d_q;
    logic [PIX_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic [LINE_W-1:0]  line_cnt_q, line_cnt_d;
    logic               bad_q, bad_d;
    logic               wr_en_q, wr_en_d;
    logic [23:0]        wr_data_q, wr_data_d;
    logic [1:0]         wr_bank_q, wr_bank_d;
    logic [1:0]         rd_bank_q, rd_bank_d;
    logic [1:0]         latest_q, latest_d;
    logic               latest_valid_q, latest_valid_d;
    logic [TH_W-1:0]    th_q, th_d;
    logic [TH_W-1:0]    pend_th_q, pend_th_d;
    logic               pend_valid_q, pend_valid_d;
    logic               frame_err_q, frame_err_d;

    logic sof, eof, de_rise, de_fall;
    logic is_commit, reject, good_commit, enter_cap, th_accept;

    assign sof     = vs_d_q & ~i_vs;
    assign eof     = ~vs_d_q & i_vs;
    assign de_rise = ~de_d_q & i_de;
    assign de_fall = de_d_q & ~i_de;

    always_comb begin
        state_d    = state_q;
        skip_cnt_d = '0;
        case (state_q)
            IDLE:     if (cap_en) state_d = (SKIP_FRAMES == 0) ? WAIT_SOF : SKIP;
            SKIP: begin
                skip_cnt_d = skip_cnt_q;
                if (sof) begin
                    skip_cnt_d = skip_cnt_q + SKIP_W'(1);
                    if (skip_cnt_q == SKIP_LAST) state_d = WAIT_SOF;
                end
            end
            WAIT_SOF: if (sof) state_d = CAPTURE;
            CAPTURE:  if (eof) state_d = COMMIT;
            COMMIT:   state_d = WAIT_SOF;
            default:  state_d = IDLE;
        endcase
        // Dropping enable abandons whatever frame is in flight.
        if (!cap_en) state_d = IDLE;
    end

    always_comb begin
        pix_cnt_d  = '0;
        line_cnt_d = '0;
        bad_d      = 1'b0;
        if (state_q == CAPTURE) begin
            pix_cnt_d  = pix_cnt_q;
            line_cnt_d = line_cnt_q;
            bad_d      = bad_q;
            if (i_de) begin
                if (de_rise)                  pix_cnt_d = PIX_W'(1);
                else if (pix_cnt_q != PIX_MAX) pix_cnt_d = pix_cnt_q + PIX_W'(1);
            end
            if (de_rise && line_cnt_q != LINE_MAX) line_cnt_d = line_cnt_q + LINE_W'(1);
            if (de_fall && pix_cnt_q != PIX_W'(H_ACTIVE)) bad_d = 1'b1;
        end
    end

    assign is_commit   = (state_q == COMMIT) && cap_en;
    assign reject      = is_commit && (bad_q || line_cnt_q != LINE_W'(V_ACTIVE));
    assign good_commit = is_commit && !reject;
    assign enter_cap   = (state_q == WAIT_SOF) && (state_d == CAPTURE);
    assign th_accept   = cfg_valid && !pend_valid_q;

    always_comb begin
        wr_en_d        = i_de && (state_d == CAPTURE);
        wr_data_d      = i_data;
        frame_err_d    = reject;
        latest_d       = good_commit ? wr_bank_q : latest_q;
        latest_valid_d = latest_valid_q | good_commit;
        rd_bank_d      = (rd_sof && latest_valid_d) ? latest_d : rd_bank_q;
        wr_bank_d      = wr_bank_q;
        // Next writer bank avoids both the bank being read and the newest complete frame.
        if (good_commit) begin
            if (rd_bank_d != 2'd0 && latest_d != 2'd0)      wr_bank_d = 2'd0;
            else if (rd_bank_d != 2'd1 && latest_d != 2'd1) wr_bank_d = 2'd1;
            else                                             wr_bank_d = 2'd2;
        end
    end

    always_comb begin
        th_d         = th_q;
        pend_th_d    = pend_th_q;
        pend_valid_d = pend_valid_q;
        if (enter_cap && pend_valid_q) begin
            th_d         = pend_th_q;
            pend_valid_d = 1'b0;
        end
        if (th_accept) begin
            pend_th_d    = cfg_th;
            pend_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            skip_cnt_q     <= '0;
            vs_d_q         <= 1'b0;
            de_d_q         <= 1'b0;
            pix_cnt_q      <= '0;
            line_cnt_q     <= '0;
            bad_q          <= 1'b0;
            wr_en_q        <= 1'b0;
            wr_data_q      <= '0;
            wr_bank_q      <= 2'd0;
            rd_bank_q      <= 2'd2;
            latest_q       <= 2'd1;
            latest_valid_q <= 1'b0;
            th_q           <= '0;
            pend_valid_q   <= 1'b0;
            frame_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            skip_cnt_q     <= skip_cnt_d;
            vs_d_q         <= i_vs;
            de_d_q         <= i_de;
            pix_cnt_q      <= pix_cnt_d;
            line_cnt_q     <= line_cnt_d;
            bad_q          <= bad_d;
            wr_en_q        <= wr_en_d;
            wr_data_q      <= wr_data_d;
            wr_bank_q      <= wr_bank_d;
            rd_bank_q      <= rd_bank_d;
            latest_q       <= latest_d;
            latest_valid_q <= latest_valid_d;
            th_q           <= th_d;
            pend_valid_q   <= pend_valid_d;
            frame_err_q    <= frame_err_d;
        end
    end

    // Pending value is qualified by pend_valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        pend_th_q <= pend_th_d;
    end

    assign cfg_ready   = ~pend_valid_q;
    assign o_wr_en     = wr_en_q;
    assign o_wr_data   = wr_data_q;
    assign o_wr_bank   = wr_bank_q;
    assign o_rd_bank   = rd_bank_q;
    assign o_th        = th_q;
    assign o_frame_err = frame_err_q;

`ifdef FRAME_STATS_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_comb begin
        frame_cnt_d = good_commit ? frame_cnt_q + 16'd1 : frame_cnt_q;
        err_cnt_d   = reject ? sat_inc8(err_cnt_q) : err_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign o_frame_cnt = frame_cnt_q;
    assign o_err_cnt   = err_cnt_q;
`else
    assign o_frame_cnt = '0;
    assign o_err_cnt   = '0;
`endif
endmodule

// File: tb/tb_frame_capture_sched.sv
// Bench for frame_capture_sched: small 4x3 geometry, two warm-up frames, table of frames
// followed by hand-written enable-drop and reset-abort sequences.
module tb_frame_capture_sched;
    localparam int SKIP = 2;
    localparam int H    = 4;
    localparam int V    = 3;
`ifdef FRAME_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk, rst_n, cap_en, i_vs, i_de, cfg_valid, cfg_ready, rd_sof;
    logic [23:0] i_data, o_wr_data;
    logic [7:0]  cfg_th, o_th, o_err_cnt;
    logic        o_wr_en, o_frame_err;
    logic [1:0]  o_wr_bank, o_rd_bank;
    logic [15:0] o_frame_cnt;

    frame_capture_sched #(.SKIP_FRAMES(SKIP), .H_ACTIVE(H), .V_ACTIVE(V), .TH_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .cap_en(cap_en), .i_vs(i_vs), .i_de(i_de), .i_data(i_data),
        .cfg_th(cfg_th), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .rd_sof(rd_sof),
        .o_wr_en(o_wr_en), .o_wr_data(o_wr_data), .o_wr_bank(o_wr_bank), .o_rd_bank(o_rd_bank),
        .o_th(o_th), .o_frame_err(o_frame_err), .o_frame_cnt(o_frame_cnt), .o_err_cnt(o_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int wr_cnt = 0, err_seen = 0, overlap = 0;
    logic [1:0]  used_bank = 2'd0;
    logic [23:0] last_data = '0;
    logic mid_ready, mid_wr_en;
    logic [7:0] mid_th;

    always @(negedge clk) begin
        if (o_wr_en) begin
            wr_cnt    <= wr_cnt + 1;
            used_bank <= o_wr_bank;
            last_data <= o_wr_data;
            if (o_wr_bank == o_rd_bank) overlap <= overlap + 1;
        end
        if (o_frame_err) err_seen <= err_seen + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int st(input int v);
        return STATS ? v : 0;
    endfunction

    task automatic check(input string nm, input int act, input int exp_v);
        tests++;
        if (act != exp_v) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp_v, exp_v);
        end
    endtask

    // One frame: vs falls (sof), nlines lines of H pixels (short_line gets H-1), then vsync
    // high with optional rd_sof landing on the COMMIT cycle.
    // th_mode 1: offer mid-frame; 2: offer on the sof cycle. abort 1: drop cap_en; 2: pulse rst_n.
    task automatic run_frame(input int fid, input int nlines, input int short_line, input bit rd_at,
                             input int th_mode, input int th_val, input int abort);
        int len;
        @(negedge clk);
        i_vs = 1'b0; i_de = 1'b0;
        if (th_mode == 2) begin cfg_valid = 1'b1; cfg_th = 8'(th_val); end
        @(negedge clk);
        cfg_valid = 1'b0;
        for (int l = 0; l < nlines; l++) begin
            len = (l == short_line) ? H - 1 : H;
            for (int p = 0; p < len; p++) begin
                i_de = 1'b1;
                i_data = {8'(fid), 8'(l), 8'(p)};
                if (l == 0 && p == 1) begin
                    if (th_mode == 1) begin cfg_valid = 1'b1; cfg_th = 8'(th_val); end
                    if (abort == 1) cap_en = 1'b0;
                    if (abort == 2) rst_n = 1'b0;
                end
                @(negedge clk);
                cfg_valid = 1'b0;
                if (l == 0 && p == 1) begin
                    mid_ready = cfg_ready;
                    mid_th    = o_th;
                    mid_wr_en = o_wr_en;
                    rst_n     = 1'b1;
                end
            end
            i_de = 1'b0;
            @(negedge clk);
            @(negedge clk);
        end
        i_vs = 1'b1;
        @(negedge clk);
        rd_sof = rd_at;
        @(negedge clk);
        rd_sof = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        int nlines; int short_line; bit rd_at; int th_mode; int th_val;
        int exp_wr; int exp_err; int exp_used; int exp_wr_bank; int exp_rd_bank;
        int exp_th; int exp_ready; int exp_fcnt; int exp_ecnt;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int wr0, er0, fc0, ec0;
        //            lines short rd  thm thv    wr err used wb rb th    rdy fc ec
        vecs[0]  = '{3, -1, 1'b0, 0, 0,     0,  0, -1, 0, 2, 0,    1, 0, 0};
        vecs[1]  = '{3, -1, 1'b0, 0, 0,     0,  0, -1, 0, 2, 0,    1, 0, 0};
        vecs[2]  = '{3, -1, 1'b0, 0, 0,     12, 0, 0,  1, 2, 0,    1, 1, 0};
        vecs[3]  = '{3, -1, 1'b0, 1, 'h40,  12, 0, 1,  0, 2, 0,    0, 2, 0};
        vecs[4]  = '{3, -1, 1'b0, 0, 0,     12, 0, 0,  1, 2, 'h40, 1, 3, 0};
        vecs[5]  = '{3, 1,  1'b0, 2, 'h55,  11, 1, 1,  1, 2, 'h40, 0, 3, 1};
        vecs[6]  = '{2, -1, 1'b0, 0, 0,     8,  1, 1,  1, 2, 'h55, 1, 3, 2};
        vecs[7]  = '{4, -1, 1'b0, 0, 0,     16, 1, 1,  1, 2, 'h55, 1, 3, 3};
        vecs[8]  = '{3, -1, 1'b1, 0, 0,     12, 0, 1,  0, 1, 'h55, 1, 4, 3};
        vecs[9]  = '{3, -1, 1'b0, 0, 0,     12, 0, 0,  2, 1, 'h55, 1, 5, 3};
        vecs[10] = '{3, -1, 1'b0, 0, 0,     12, 0, 2,  0, 1, 'h55, 1, 6, 3};

        rst_n = 1'b0; cap_en = 1'b0; i_vs = 1'b1; i_de = 1'b0; i_data = '0;
        cfg_th = '0; cfg_valid = 1'b0; rd_sof = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_wr_en", o_wr_en, 0);
        check("rst_wr_data", o_wr_data, 0);
        check("rst_wr_bank", o_wr_bank, 0);
        check("rst_rd_bank", o_rd_bank, 2);
        check("rst_th", o_th, 0);
        check("rst_frame_err", o_frame_err, 0);
        check("rst_frame_cnt", o_frame_cnt, 0);
        check("rst_err_cnt", o_err_cnt, 0);

        // Reader start before any committed frame leaves the read bank alone.
        rd_sof = 1'b1;
        @(negedge clk);
        rd_sof = 1'b0;
        @(negedge clk);
        check("rd_sof_no_valid", o_rd_bank, 2);

        cap_en = 1'b1;
        repeat (2) @(negedge clk);

        for (int k = 0; k < 11; k++) begin
            wr0 = wr_cnt; er0 = err_seen;
            run_frame(k, vecs[k].nlines, vecs[k].short_line, vecs[k].rd_at,
                      vecs[k].th_mode, vecs[k].th_val, 0);
            check($sformatf("f%0d_wr_cycles", k), wr_cnt - wr0, vecs[k].exp_wr);
            check($sformatf("f%0d_err_pulses", k), err_seen - er0, vecs[k].exp_err);
            check($sformatf("f%0d_wr_bank", k), o_wr_bank, vecs[k].exp_wr_bank);
            check($sformatf("f%0d_rd_bank", k), o_rd_bank, vecs[k].exp_rd_bank);
            check($sformatf("f%0d_th", k), o_th, vecs[k].exp_th);
            check($sformatf("f%0d_cfg_ready", k), cfg_ready, vecs[k].exp_ready);
            check($sformatf("f%0d_frame_cnt", k), o_frame_cnt, st(vecs[k].exp_fcnt));
            check($sformatf("f%0d_err_cnt", k), o_err_cnt, st(vecs[k].exp_ecnt));
            if (vecs[k].exp_used >= 0)
                check($sformatf("f%0d_bank_used", k), used_bank, vecs[k].exp_used);
            if (vecs[k].exp_wr > 0)
                check($sformatf("f%0d_last_data", k), last_data,
                      (k << 16) | ((vecs[k].nlines - 1) << 8) | (H - 1));
            if (vecs[k].th_mode == 1) begin
                check($sformatf("f%0d_mid_cfg_ready", k), mid_ready, 0);
                check($sformatf("f%0d_mid_th", k), mid_th, 0);
            end
        end

        // Stand-alone reader start picks up the newest complete frame (bank 2).
        rd_sof = 1'b1;
        @(negedge clk);
        rd_sof = 1'b0;
        @(negedge clk);
        check("rd_sof_latest", o_rd_bank, 2);
        check("rd_sof_wr_bank", o_wr_bank, 0);

        // Enable dropped mid-capture: writes stop next cycle, no commit.
        wr0 = wr_cnt; er0 = err_seen; fc0 = o_frame_cnt; ec0 = o_err_cnt;
        run_frame(20, 3, -1, 1'b0, 0, 0, 1);
        check("capdrop_wr_en_next", mid_wr_en, 0);
        check("capdrop_wr_cycles", wr_cnt - wr0, 1);
        check("capdrop_err_pulses", err_seen - er0, 0);
        check("capdrop_frame_cnt", o_frame_cnt, fc0);
        check("capdrop_err_cnt", o_err_cnt, ec0);
        check("capdrop_wr_bank", o_wr_bank, 0);

        // Re-enable: warm-up skip applies again.
        cap_en = 1'b1;
        wr0 = wr_cnt;
        run_frame(21, 3, -1, 1'b0, 0, 0, 0);
        run_frame(22, 3, -1, 1'b0, 0, 0, 0);
        check("reskip_wr_cycles", wr_cnt - wr0, 0);

        // Reset pulsed mid-capture.
        wr0 = wr_cnt; er0 = err_seen;
        run_frame(23, 3, -1, 1'b0, 0, 0, 2);
        check("rstabort_wr_en_next", mid_wr_en, 0);
        check("rstabort_wr_cycles", wr_cnt - wr0, 1);
        check("rstabort_err_pulses", err_seen - er0, 0);
        check("rstabort_th", o_th, 0);
        check("rstabort_rd_bank", o_rd_bank, 2);
        check("rstabort_wr_bank", o_wr_bank, 0);
        check("rstabort_frame_cnt", o_frame_cnt, 0);

        check("bank_overlap", overlap, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
